// File: rtl/seg_disp_pkg.sv
// Shared mode encodings and the active-low 7-segment decode table for the BCD counter display.
package seg_disp_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Segments active-low, bit7 is the decimal point and stays off.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter: shift load, carry-in increment and borrow-in decrement.
module bcd_digit (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  input  logic       bin,
  input  logic       shift_en,
  input  logic [3:0] shift_in,
  output logic [3:0] digit,
  output logic       cout,
  output logic       bout
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (shift_en) begin
      digit_d = shift_in;
    end else if (inc && cin) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end else if (dec && bin) begin
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign cout  = inc && cin && (digit_q == 4'd9);
  assign bout  = dec && bin && (digit_q == 4'd0);

endmodule

// File: rtl/seg_bcd_counter_display.sv
// N-digit BCD up/down counter with prescaled timebase, shift-in load, wrap pulse and
// registered 7-segment outputs with optional leading-zero blanking.
module seg_bcd_counter_display
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 5,
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned LZ_BLANK   = 1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [1:0]              mode,
  input  logic                    run,
  input  logic [3:0]              bcd_in,
  input  logic                    load_stb,
  output logic [8*NUM_DIGITS-1:0] hex,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [1:0]              mode_q;
  logic                    load_q;
  logic                    wrap_q, wrap_d;
  logic [8*NUM_DIGITS-1:0] hex_q, hex_d;

  logic                  tick, active, mode_chg;
  logic                  inc, dec, shift_en;
  logic [3:0]            din_clamp;
  logic [3:0]            digit     [NUM_DIGITS];
  logic [3:0]            shift_src [NUM_DIGITS];
  logic [NUM_DIGITS:0]   carry, borrow;
  logic [NUM_DIGITS-1:0] cout, bout;

  // A mode change restarts the period and swallows a coincident terminal count.
  always_comb begin
    active   = run && ((mode == MODE_UP) || (mode == MODE_DOWN));
    mode_chg = (mode != mode_q);
    presc_d  = '0;
    tick     = 1'b0;
    if (active && !mode_chg) begin
      if (presc_q == PRESC_MAX) begin
        tick = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign inc       = tick && (mode == MODE_UP);
  assign dec       = tick && (mode == MODE_DOWN);
  assign shift_en  = (mode == MODE_LOAD) && load_stb && !load_q;
  assign din_clamp = (bcd_in > 4'd9) ? 4'd9 : bcd_in;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign shift_src[i] = din_clamp;
    end else begin : g_rest
      assign shift_src[i] = digit[i-1];
    end

    bcd_digit u_digit (
      .clk_i    (clk_clk),
      .rst_ni   (reset_reset_n),
      .inc      (inc),
      .dec      (dec),
      .cin      (carry[i]),
      .bin      (borrow[i]),
      .shift_en (shift_en),
      .shift_in (shift_src[i]),
      .digit    (digit[i]),
      .cout     (cout[i]),
      .bout     (bout[i])
    );

    assign carry[i+1]         = cout[i];
    assign borrow[i+1]        = bout[i];
    assign count_bcd[4*i +: 4] = digit[i];
  end

  assign wrap_d = carry[NUM_DIGITS] || borrow[NUM_DIGITS];

  // Scan from the MS digit down; a digit blanks while everything above and itself is zero.
  always_comb begin
    logic upper_nz;
    logic blank;
    hex_d    = '0;
    upper_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_nz = upper_nz || (digit[i] != 4'd0);
      blank    = (LZ_BLANK != 0) && (i != 0) && !upper_nz;
      hex_d[8*i +: 8] = blank ? SEG_BLANK : seg_decode(digit[i]);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      presc_q <= '0;
      mode_q  <= MODE_HOLD;
      load_q  <= 1'b0;
      wrap_q  <= 1'b0;
      hex_q   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      presc_q <= presc_d;
      mode_q  <= mode;
      load_q  <= load_stb;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
    end
  end

  assign hex  = hex_q;
  assign wrap = wrap_q;

endmodule
